// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared types and constants for the manycore AXI-Lite link and its request-side arbiter.
package bsg_manycore_link_to_axil_pkg;

   localparam int host_fifo_width_gp = 128;
   localparam int tx_req_credits_gp  = 4;

   typedef enum logic [0:0] {
      e_idle,
      e_burst
   } bsg_manycore_axil_req_arb_state_e;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_round_robin_arb.sv
// Round-robin winner search: first requester after the last granted one, wrapping upward.
module bsg_round_robin_arb
   import bsg_manycore_link_to_axil_pkg::*;
#(
   parameter int num_req_p = 2,
   localparam int id_width_lp = safe_clog2(num_req_p)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [num_req_p-1:0]   reqs_i,
   input  logic                   yumi_i,
   output logic [id_width_lp-1:0] grant_id_o,
   output logic                   v_o
);

   logic [id_width_lp-1:0] last_r;
   logic [id_width_lp-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest candidate after last_r wins.
   always_comb begin
      grant_id_o = '0;
      v_o        = 1'b0;
      idx        = '0;
      for (int k = num_req_p; k >= 1; k--) begin
         idx = id_width_lp'((int'(last_r) + k) % num_req_p);
         if (reqs_i[idx]) begin
            grant_id_o = idx;
            v_o        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         last_r <= id_width_lp'(num_req_p - 1);
      else if (yumi_i)
         last_r <= grant_id_o;
   end

endmodule

// File: rtl/bsg_manycore_axil_req_packet_arb.sv
// Packet-atomic round-robin arbiter sharing the tx link request port among several word streams.
module bsg_manycore_axil_req_packet_arb
   import bsg_manycore_link_to_axil_pkg::*;
#(
   parameter int num_req_p         = 2,
   parameter int axil_data_width_p = 32,
   parameter int ratio_p           = host_fifo_width_gp / axil_data_width_p,
   parameter int credit_els_p      = ratio_p * tx_req_credits_gp,
   localparam int credit_width_lp  = $clog2(credit_els_p + 1),
   localparam int id_width_lp      = safe_clog2(num_req_p),
   localparam int beat_width_lp    = safe_clog2(ratio_p)
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [num_req_p*axil_data_width_p-1:0] req_data_i,
   input  logic [num_req_p-1:0]                   req_v_i,
   output logic [num_req_p-1:0]                   req_ready_o,
   output logic [axil_data_width_p-1:0]           axil_req_o,
   output logic                                   axil_req_v_o,
   input  logic                                   axil_req_ready_i,
   input  logic [credit_width_lp-1:0]             req_credits_i,
   output logic [id_width_lp-1:0]                 grant_id_o,
   output logic                                   busy_o
);

   bsg_manycore_axil_req_arb_state_e state_r;
   logic [id_width_lp-1:0]   grant_r;
   logic [beat_width_lp-1:0] beat_r;

   logic [id_width_lp-1:0] winner;
   logic                   winner_v;
   logic                   credit_ok;
   logic                   do_grant;
   logic                   in_burst;
   logic                   xfer;
   logic                   last_beat;

   assign in_burst  = (state_r == e_burst);
   assign credit_ok = (req_credits_i >= credit_width_lp'(ratio_p));
   assign do_grant  = !in_burst && winner_v && credit_ok;

   bsg_round_robin_arb #(
      .num_req_p(num_req_p)
   ) rr_arb (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .reqs_i    (req_v_i),
      .yumi_i    (do_grant),
      .grant_id_o(winner),
      .v_o       (winner_v)
   );

   // Combinational mux onto the link: no word is ever stored here.
   assign axil_req_o   = req_data_i[grant_r*axil_data_width_p +: axil_data_width_p];
   assign axil_req_v_o = in_burst && req_v_i[grant_r];

   always_comb begin
      req_ready_o = '0;
      if (in_burst)
         req_ready_o[grant_r] = axil_req_ready_i;
   end

   assign xfer      = axil_req_v_o && axil_req_ready_i;
   assign last_beat = (beat_r == beat_width_lp'(ratio_p - 1));

   // Credits are checked only at grant time; vacancy cannot shrink while this block owns the port.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_idle;
         grant_r <= '0;
         beat_r  <= '0;
      end else begin
         case (state_r)
            e_idle: begin
               if (do_grant) begin
                  grant_r <= winner;
                  beat_r  <= '0;
                  state_r <= e_burst;
               end
            end
            e_burst: begin
               if (xfer) begin
                  if (last_beat) begin
                     beat_r  <= '0;
                     state_r <= e_idle;
                  end else begin
                     beat_r  <= beat_r + 1'b1;
                  end
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

   assign busy_o     = in_burst;
   assign grant_id_o = grant_r;

endmodule

// File: tb/tb_bsg_manycore_axil_req_packet_arb.sv
// Directed vector bench for the packet-atomic request arbiter (2 requesters, 4 words per packet).
module tb_bsg_manycore_axil_req_packet_arb;

   localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
   localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002, B3 = 32'hB000_0003;

   logic        clk;
   logic        reset;
   logic [63:0] req_data;
   logic [1:0]  req_v;
   logic [1:0]  req_ready;
   logic [31:0] axil_req;
   logic        axil_req_v;
   logic        axil_req_ready;
   logic [4:0]  req_credits;
   logic [0:0]  grant_id;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cur    = -1;

   bsg_manycore_axil_req_packet_arb #(
      .num_req_p        (2),
      .axil_data_width_p(32),
      .ratio_p          (4),
      .credit_els_p     (16)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .req_data_i      (req_data),
      .req_v_i         (req_v),
      .req_ready_o     (req_ready),
      .axil_req_o      (axil_req),
      .axil_req_v_o    (axil_req_v),
      .axil_req_ready_i(axil_req_ready),
      .req_credits_i   (req_credits),
      .grant_id_o      (grant_id),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        rdy;
      logic [4:0]  cr;
      logic        ev;
      logic [31:0] edat;
      logic [1:0]  erdy;
      logic        ebusy;
      logic        egid;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic [1:0] v, input logic [31:0] d0,
                               input logic [31:0] d1, input logic rdy, input logic [4:0] cr,
                               input logic ev, input logic [31:0] edat, input logic [1:0] erdy,
                               input logic ebusy, input logic egid);
      vec_t t;
      t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy; t.cr = cr;
      t.ev = ev; t.edat = edat; t.erdy = erdy; t.ebusy = ebusy; t.egid = egid;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vector %0d): got %h expected %h", nm, cur, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cyc;

      // Single requester
      add(0, 2'b01, A0, 0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b01, A0, 0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(0, 2'b01, A1, 0, 1, 16, 1, A1, 2'b01, 1, 0);
      add(0, 2'b01, A2, 0, 1, 16, 1, A2, 2'b01, 1, 0);
      add(0, 2'b01, A3, 0, 1, 16, 1, A3, 2'b01, 1, 0);
      add(0, 2'b00, 0,  0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(1, 2'b00, 0,  0, 1, 16, 0, 0,  2'b00, 0, 0);
      // Contention: A packet, gap, B packet, gap, A packet
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b11, A0, B0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(0, 2'b11, A1, B0, 1, 16, 1, A1, 2'b01, 1, 0);
      add(0, 2'b11, A2, B0, 1, 16, 1, A2, 2'b01, 1, 0);
      add(0, 2'b11, A3, B0, 1, 16, 1, A3, 2'b01, 1, 0);
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b11, A0, B0, 1, 16, 1, B0, 2'b10, 1, 1);
      add(0, 2'b11, A0, B1, 1, 16, 1, B1, 2'b10, 1, 1);
      add(0, 2'b11, A0, B2, 1, 16, 1, B2, 2'b10, 1, 1);
      add(0, 2'b11, A0, B3, 1, 16, 1, B3, 2'b10, 1, 1);
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 1);
      add(0, 2'b11, A0, B0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(0, 2'b11, A1, B0, 1, 16, 1, A1, 2'b01, 1, 0);
      add(0, 2'b11, A2, B0, 1, 16, 1, A2, 2'b01, 1, 0);
      add(0, 2'b11, A3, B0, 1, 16, 1, A3, 2'b01, 1, 0);
      add(0, 2'b00, 0,  0,  1, 16, 0, 0,  2'b00, 0, 0);
      add(1, 2'b00, 0,  0,  1, 16, 0, 0,  2'b00, 0, 0);
      // Credit gate at ratio-1 vs ratio
      add(0, 2'b10, 0, B0, 1, 3, 0, 0,  2'b00, 0, 0);
      add(0, 2'b10, 0, B0, 1, 3, 0, 0,  2'b00, 0, 0);
      add(0, 2'b10, 0, B0, 1, 4, 0, 0,  2'b00, 0, 0);
      add(0, 2'b10, 0, B0, 1, 4, 1, B0, 2'b10, 1, 1);
      add(0, 2'b10, 0, B1, 1, 4, 1, B1, 2'b10, 1, 1);
      add(0, 2'b10, 0, B2, 1, 4, 1, B2, 2'b10, 1, 1);
      add(0, 2'b10, 0, B3, 1, 4, 1, B3, 2'b10, 1, 1);
      add(0, 2'b00, 0, 0,  1, 4, 0, 0,  2'b00, 0, 1);
      add(1, 2'b00, 0, 0,  1, 16, 0, 0, 2'b00, 0, 1);
      // Back-pressure and valid bubbles; requester 1 never readied
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b11, A0, B0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(0, 2'b11, A1, B0, 0, 16, 1, A1, 2'b00, 1, 0);
      add(0, 2'b11, A1, B0, 1, 16, 1, A1, 2'b01, 1, 0);
      add(0, 2'b10, A2, B0, 0, 16, 0, 0,  2'b00, 1, 0);
      add(0, 2'b10, A2, B0, 1, 16, 0, 0,  2'b01, 1, 0);
      add(0, 2'b10, A2, B0, 0, 16, 0, 0,  2'b00, 1, 0);
      add(0, 2'b11, A2, B0, 1, 16, 1, A2, 2'b01, 1, 0);
      add(0, 2'b11, A3, B0, 0, 16, 1, A3, 2'b00, 1, 0);
      add(0, 2'b11, A3, B0, 1, 16, 1, A3, 2'b01, 1, 0);
      add(0, 2'b00, 0,  0,  0, 16, 0, 0,  2'b00, 0, 0);
      add(1, 2'b00, 0,  0,  1, 16, 0, 0,  2'b00, 0, 0);
      // Reset mid-burst, then requester 0 wins again over requester 1
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b11, A0, B0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(0, 2'b11, A1, B0, 1, 16, 1, A1, 2'b01, 1, 0);
      add(1, 2'b11, A2, B0, 1, 16, 1, A2, 2'b01, 1, 0);
      add(0, 2'b11, A0, B0, 1, 16, 0, 0,  2'b00, 0, 0);
      add(0, 2'b11, A0, B0, 1, 16, 1, A0, 2'b01, 1, 0);
      add(1, 2'b11, A1, B0, 1, 16, 1, A1, 2'b01, 1, 0);

      // Power-on reset
      reset = 1'b1; req_v = 2'b00; req_data = '0; axil_req_ready = 1'b1; req_credits = 5'd16;
      @(negedge clk);
      @(negedge clk); #1;
      chk("reset_busy",  busy,       0);
      chk("reset_v",     axil_req_v, 0);
      chk("reset_ready", req_ready,  0);
      chk("reset_gid",   grant_id,   0);

      foreach (vecs[i]) begin
         @(negedge clk);
         cur            = i;
         reset          = vecs[i].rst;
         req_v          = vecs[i].v;
         req_data       = {vecs[i].d1, vecs[i].d0};
         axil_req_ready = vecs[i].rdy;
         req_credits    = vecs[i].cr;
         #1;
         chk("v_o",     axil_req_v, vecs[i].ev);
         chk("ready_o", req_ready,  vecs[i].erdy);
         chk("busy_o",  busy,       vecs[i].ebusy);
         chk("grant_o", grant_id,   vecs[i].egid);
         if (vecs[i].ev)
            chk("data_o", axil_req, vecs[i].edat);
      end

      // Held below the credit threshold for a while, then released
      cur = -2;
      @(negedge clk);
      reset = 1'b0; req_v = 2'b01; req_data = {B0, A0}; axil_req_ready = 1'b1; req_credits = 5'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("gate_busy",  busy,      0);
         chk("gate_ready", req_ready, 0);
      end
      @(negedge clk); req_credits = 5'd4; #1;
      chk("gate_grant_cycle", busy, 0);
      @(negedge clk); #1;
      chk("gate_first_v", axil_req_v, 1);
      chk("gate_first_d", axil_req,   A0);
      w   = 0;
      cyc = 0;
      while (busy && cyc < 20) begin
         if (axil_req_v && axil_req_ready) begin
            chk("gate_word", axil_req, 32'(A0 + 32'(w)));
            w++;
         end
         @(negedge clk);
         req_data[31:0] = 32'(A0 + 32'(w));
         #1;
         cyc++;
      end
      chk("gate_word_count", 32'(w), 4);
      chk("gate_burst_end",  busy,   0);
      req_v = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
